// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM states, sample type, bit reversal and twiddle generation for fft_iter.
package fft_pkg;
    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_e;
    typedef struct packed {
        logic signed [15:0] im;
        logic signed [15:0] re;
    } cplx16_t;
    typedef struct packed {
        longint re;
        longint im;
    } tw_t;
    localparam longint TWO_PI_Q30 = 64'sd6746518852;

    function automatic int bitrev(input int k, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    // Taylor series in Q30; callers keep the angle within the first octant.
    function automatic longint taylor(input int m, input int n, input bit odd);
        longint x, term, sum;
        x = TWO_PI_Q30 * m / n;
        term = odd ? x : 64'sd1 <<< 30;
        sum = term;
        for (int i = 1; i <= 10; i++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / (2 * i - 1 + int'(odd)) / (2 * i + int'(odd));
            sum = sum + term;
        end
        return sum;
    endfunction

    function automatic tw_t twiddle(input int k, input int n, input int frac);
        int q, j;
        longint c, s, re, im;
        tw_t t;
        q = n / 4;
        j = k > q ? k - q : k;
        c = 8 * j <= n ? taylor(j, n, 1'b0) : taylor(q - j, n, 1'b1);
        s = 8 * j <= n ? taylor(j, n, 1'b1) : taylor(q - j, n, 1'b0);
        re = k > q ? -s : c;
        im = k > q ? c : s;
        t.re = (re + (64'sd1 <<< (29 - frac))) >>> (30 - frac);
        t.im = -((im + (64'sd1 <<< (29 - frac))) >>> (30 - frac));
        return t;
    endfunction
endpackage

// File: rtl/fft_bfly_sat.sv
// fft_bfly_sat: radix-2 butterfly with rounded twiddle product, optional halving and saturation.
module fft_bfly_sat #(
    parameter int DW   = 16,
    parameter int TW   = 17,
    parameter int FRAC = 15
) (
    input  logic signed [1:0][DW-1:0] a_i,
    input  logic signed [1:0][DW-1:0] b_i,
    input  logic signed [1:0][TW-1:0] w_i,
    input  logic                      scale_i,
    output logic signed [1:0][DW-1:0] x_o,
    output logic signed [1:0][DW-1:0] y_o,
    output logic                      ovf_o
);
    localparam int PW = DW + TW + 2;
    localparam logic signed [PW-1:0] RND  = PW'(1) << (FRAC - 1);
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = -MAXV - 1;

    logic signed [PW-1:0] ar, ai, br, bi, wr, wi, pr, pim;
    logic signed [PW-1:0] d [4];
    logic signed [PW-1:0] v [4];
    logic [3:0] o;
    logic [DW-1:0] q [4];

    always_comb begin
        ar = PW'($signed(a_i[0]));
        ai = PW'($signed(a_i[1]));
        br = PW'($signed(b_i[0]));
        bi = PW'($signed(b_i[1]));
        wr = PW'($signed(w_i[0]));
        wi = PW'($signed(w_i[1]));
        pr = (wr * br - wi * bi + RND) >>> FRAC;
        pim = (wr * bi + wi * br + RND) >>> FRAC;
        d[0] = ar + pr;
        d[1] = ai + pim;
        d[2] = ar - pr;
        d[3] = ai - pim;
        for (int i = 0; i < 4; i++) begin
            v[i] = scale_i ? d[i] >>> 1 : d[i];
            o[i] = v[i] > MAXV || v[i] < MINV;
            q[i] = o[i] ? (v[i][PW-1] ? DW'(MINV) : DW'(MAXV)) : v[i][DW-1:0];
        end
    end

    assign x_o = {q[1], q[0]};
    assign y_o = {q[3], q[2]};
    assign ovf_o = |o;
endmodule

// File: rtl/fft_iter.sv
// fft_iter: iterative in-place radix-2 DIT FFT/IFFT, one butterfly per cycle.
// Samples load in bit-reversed order, transform in place, then unload in bin order.
module fft_iter
    import fft_pkg::*;
#(
    parameter int POINT_FFT_POW2 = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int FRAC_BITS      = 15
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic signed [1:0][DATA_WIDTH-1:0] in_data_i,
    input  logic                              inv_i,
    input  logic                              scale_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic signed [1:0][DATA_WIDTH-1:0] out_data_o,
    output logic                              out_last_o,
    output logic                              busy_o,
    output logic                              ovf_o
);
    localparam int P = POINT_FFT_POW2;
    localparam int POINT_FFT = 1 << P;
    localparam int TW_W = FRAC_BITS + 2;

    state_e state_q, state_d;
    logic [P-1:0] cnt_q, cnt_d, bx, mask, a_addr, b_addr, tw_idx;
    logic [3:0] stage_q, stage_d;
    logic inv_q, inv_d, scale_q, scale_d, ovf_q, ovf_d, bf_ovf, last_b;
    logic [1:0][DATA_WIDTH-1:0] ram [POINT_FFT];
    logic signed [1:0][TW_W-1:0] rom [POINT_FFT/2];
    logic signed [1:0][TW_W-1:0] w;
    logic signed [1:0][DATA_WIDTH-1:0] bf_x, bf_y;

    for (genvar g = 0; g < POINT_FFT / 2; g++) begin : g_rom
        localparam tw_t T = twiddle(g, POINT_FFT, FRAC_BITS);
        assign rom[g] = {TW_W'(T.im), TW_W'(T.re)};
    end

    // Inserting a zero at bit 'stage' of the butterfly index gives the upper operand.
    always_comb begin
        bx = {1'b0, cnt_q[P-2:0]};
        mask = ~({P{1'b1}} << stage_q);
        a_addr = ((bx & ~mask) << 1) | (bx & mask);
        b_addr = a_addr | (mask + 1'b1);
        tw_idx = (bx & mask) << (4'(P - 1) - stage_q);
        w = {inv_q ? -rom[tw_idx[P-2:0]][1] : rom[tw_idx[P-2:0]][1], rom[tw_idx[P-2:0]][0]};
        last_b = &cnt_q[P-2:0];
    end

    fft_bfly_sat #(.DW(DATA_WIDTH), .TW(TW_W), .FRAC(FRAC_BITS)) u_bfly (
        .a_i     (ram[a_addr]),
        .b_i     (ram[b_addr]),
        .w_i     (w),
        .scale_i (scale_q),
        .x_o     (bf_x),
        .y_o     (bf_y),
        .ovf_o   (bf_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        stage_d = stage_q;
        inv_d = inv_q;
        scale_d = scale_q;
        ovf_d = ovf_q;
        if (state_q == S_LOAD && in_valid_i) begin
            cnt_d = cnt_q + 1'b1;
            inv_d = cnt_q == '0 ? inv_i : inv_q;
            scale_d = cnt_q == '0 ? scale_i : scale_q;
            ovf_d = cnt_q == '0 ? 1'b0 : ovf_q;
            state_d = &cnt_q ? S_COMPUTE : S_LOAD;
        end else if (state_q == S_COMPUTE) begin
            ovf_d = ovf_q | bf_ovf;
            cnt_d = last_b ? '0 : cnt_q + 1'b1;
            stage_d = last_b ? (stage_q == 4'(P - 1) ? '0 : stage_q + 1'b1) : stage_q;
            state_d = last_b && stage_q == 4'(P - 1) ? S_UNLOAD : S_COMPUTE;
        end else if (state_q == S_UNLOAD && out_ready_i) begin
            cnt_d = cnt_q + 1'b1;
            state_d = &cnt_q ? S_LOAD : S_UNLOAD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_LOAD;
            cnt_q <= '0;
            stage_q <= '0;
            inv_q <= 1'b0;
            scale_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            stage_q <= stage_d;
            inv_q <= inv_d;
            scale_q <= scale_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == S_LOAD && in_valid_i) begin
            ram[P'(bitrev(int'(cnt_q), P))] <= in_data_i;
        end else if (state_q == S_COMPUTE) begin
            ram[a_addr] <= bf_x;
            ram[b_addr] <= bf_y;
        end
    end

    assign in_ready_o = state_q == S_LOAD;
    assign out_valid_o = state_q == S_UNLOAD;
    assign busy_o = state_q != S_LOAD;
    assign out_last_o = out_valid_o && &cnt_q;
    assign out_data_o = ram[cnt_q];
    assign ovf_o = ovf_q;
endmodule

// File: tb/tb_fft_iter.sv
// tb_fft_iter: random and directed frames against a floating-point-twiddle reference FFT.
module tb_fft_iter;
    localparam int P = 4;
    localparam int N = 16;
    localparam int DW = 16;
    localparam int FB = 15;
    localparam real PI = 3.14159265358979323846;

    logic clk_i = 1'b0, rst_ni = 1'b0, in_valid_i = 1'b0, inv_i = 1'b0, scale_i = 1'b0, out_ready_i = 1'b0;
    logic in_ready_o, out_valid_o, out_last_o, busy_o, ovf_o;
    logic signed [1:0][DW-1:0] in_data_i = '0, out_data_o;
    int n_vec = 0, n_err = 0;
    int xr[N], xi[N], er[N], ei[N], gr[N], gi[N], ox[N], oy[N];
    bit eovf, govf;

    always #5 clk_i = ~clk_i;

    fft_iter #(.POINT_FFT_POW2(P), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .inv_i(inv_i), .scale_i(scale_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .busy_o(busy_o), .ovf_o(ovf_o)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < P; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    function automatic longint rnd(input real r);
        return r >= 0.0 ? longint'($floor(r + 0.5)) : -longint'($floor(-r + 0.5));
    endfunction

    function automatic longint sat(input longint v);
        if (v > (1 << (DW - 1)) - 1) begin eovf = 1; return (1 << (DW - 1)) - 1; end
        if (v < -(1 << (DW - 1))) begin eovf = 1; return -(1 << (DW - 1)); end
        return v;
    endfunction

    // Textbook radix-2 DIT transform on the current frame xr/xi.
    task automatic model(input bit inv, input bit sc);
        longint ar[N], ai[N];
        eovf = 0;
        for (int k = 0; k < N; k++) begin
            ar[rev(k)] = xr[k];
            ai[rev(k)] = xi[k];
        end
        for (int s = 0; s < P; s++) begin
            for (int b = 0; b < N / 2; b++) begin
                int h, a, c, t;
                longint wr, wi, pr, pim;
                longint xa[4];
                real ang;
                h = 1 << s;
                a = (b >> s) * 2 * h + (b & (h - 1));
                c = a + h;
                t = (b & (h - 1)) * (N / (2 * h));
                ang = 2.0 * PI * t / N;
                wr = rnd($cos(ang) * real'(1 << FB));
                wi = -rnd($sin(ang) * real'(1 << FB));
                if (inv) wi = -wi;
                pr = (wr * ar[c] - wi * ai[c] + (1 << (FB - 1))) >>> FB;
                pim = (wr * ai[c] + wi * ar[c] + (1 << (FB - 1))) >>> FB;
                xa[0] = ar[a] + pr;
                xa[1] = ai[a] + pim;
                xa[2] = ar[a] - pr;
                xa[3] = ai[a] - pim;
                for (int i = 0; i < 4; i++) if (sc) xa[i] = xa[i] >>> 1;
                ar[a] = sat(xa[0]);
                ai[a] = sat(xa[1]);
                ar[c] = sat(xa[2]);
                ai[c] = sat(xa[3]);
            end
        end
        for (int k = 0; k < N; k++) begin
            er[k] = int'(ar[k]);
            ei[k] = int'(ai[k]);
        end
    endtask

    task automatic send(input bit inv, input bit sc, input int duty);
        int k = 0, cyc = 0;
        while (k < N && cyc < 4000) begin
            in_valid_i = $urandom_range(99) < duty;
            in_data_i[0] = DW'(xr[k]);
            in_data_i[1] = DW'(xi[k]);
            inv_i = k == 0 ? inv : 1'($urandom);
            scale_i = k == 0 ? sc : 1'($urandom);
            @(negedge clk_i);
            if (in_valid_i && in_ready_o) k++;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        in_valid_i = 1'b0;
        check("send_count", k, N);
    endtask

    task automatic recv(input int duty);
        int k = 0, cyc = 0, first = -1;
        bit stall = 0;
        logic [2*DW+1:0] hold = '0;
        while (k < N && cyc < 4000) begin
            out_ready_i = $urandom_range(99) < duty;
            in_valid_i = 1'($urandom);
            in_data_i = 32'($urandom);
            @(negedge clk_i);
            check("busy_rdy", {busy_o, in_ready_o}, 2'b10);
            if (stall) check("stall_hold", {out_valid_o, out_last_o, out_data_o}, hold);
            if (out_valid_o && first < 0) first = cyc;
            stall = out_valid_o && !out_ready_i;
            hold = {out_valid_o, out_last_o, out_data_o};
            if (out_valid_o && out_ready_i) begin
                gr[k] = int'($signed(out_data_o[0]));
                gi[k] = int'($signed(out_data_o[1]));
                check($sformatf("bin_re[%0d]", k), gr[k], er[k]);
                check($sformatf("bin_im[%0d]", k), gi[k], ei[k]);
                check($sformatf("last[%0d]", k), out_last_o, k == N - 1);
                if (k == N - 1) begin
                    govf = ovf_o;
                    check("ovf", ovf_o, eovf);
                end
                k++;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        out_ready_i = 1'b0;
        in_valid_i = 1'b0;
        check("recv_count", k, N);
        check("compute_len", first, N / 2 * P);
    endtask

    task automatic run(input bit inv, input bit sc, input int din, input int dout);
        model(inv, sc);
        send(inv, sc, din);
        recv(dout);
    endtask

    task automatic rand_frame(input int amp);
        for (int k = 0; k < N; k++) begin
            xr[k] = int'($urandom_range(2 * amp - 1)) - amp;
            xi[k] = int'($urandom_range(2 * amp - 1)) - amp;
        end
    endtask

    function automatic bit near(input int v, input int ref_v, input int tol);
        return v - ref_v <= tol && ref_v - v <= tol;
    endfunction

    initial begin
        #1;
        check("reset_outs", {in_ready_o, out_valid_o, out_last_o, busy_o, ovf_o}, 5'b10000);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < N; k++) begin
            xr[k] = k == 0 ? 16'h4000 : 0;
            xi[k] = 0;
        end
        run(0, 0, 100, 100);
        for (int k = 0; k < N; k++) check($sformatf("impulse[%0d]", k), {gr[k], gi[k]}, {32'h4000, 32'h0});
        check("impulse_ovf", govf, 0);
        for (int k = 0; k < N; k++) begin
            xr[k] = 16'h0800;
            xi[k] = 0;
        end
        run(0, 0, 100, 100);
        check("dc_x0", gr[0], 32767);
        check("dc_ovf", govf, 1);
        run(0, 1, 100, 100);
        check("dcs_x0", {gr[0], gi[0]}, {32'h0800, 32'h0});
        check("dcs_ovf", govf, 0);
        for (int k = 1; k < N; k++) check($sformatf("dcs_bin[%0d]=%0d,%0d", k, gr[k], gi[k]), near(gr[k], 0, 1) && near(gi[k], 0, 1), 1);
        for (int k = 0; k < N; k++) begin
            xr[k] = int'(rnd(8192.0 * $cos(2.0 * PI * k / N)));
            xi[k] = int'(rnd(8192.0 * $sin(2.0 * PI * k / N)));
        end
        run(0, 1, 100, 100);
        for (int k = 0; k < N; k++) check($sformatf("tone_bin[%0d]=%0d,%0d", k, gr[k], gi[k]), near(gr[k], k == 1 ? 8192 : 0, 2) && near(gi[k], 0, 2), 1);
        rand_frame(4096);
        ox = xr;
        oy = xi;
        run(0, 1, 100, 100);
        xr = gr;
        xi = gi;
        run(1, 0, 100, 100);
        for (int k = 0; k < N; k++) check($sformatf("round_trip[%0d]=%0d,%0d", k, gr[k], gi[k]), near(gr[k], ox[k], N) && near(gi[k], oy[k], N), 1);
        for (int f = 0; f < 20; f++) begin
            rand_frame(f % 2 == 0 ? 32768 : 8192);
            run(1'($urandom), 1'($urandom), 30, 30);
        end
        rand_frame(32768);
        send(0, 0, 100);
        repeat (10) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_outs", {in_ready_o, out_valid_o, out_last_o, busy_o, ovf_o}, 5'b10000);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        rand_frame(16384);
        run(1'($urandom), 1'($urandom), 70, 70);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
